trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
Sequences trap entry, mret return and WFI sleep for the 5-stage pipeline. It consumes writeback-stage retire/exception/mret/wfi status plus raw interrupt lines and CSR enables. It produces gated interrupt requests toward writeback, a registered fetch redirect, a pipeline flush window and a WFI stall. It owns the only state machine that decides when control flow leaves the sequential PC path.

Parameters:
FLUSH_CYCLES, 3, cycles flush stays asserted after a redirect (covers fetch..memory stages); legal range 1..15
VECTORED_EN, 1, when 1 honour mtvec.MODE=1 for interrupts; when 0 always use direct mode

Ports:
clk  in  1  core clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
wb_valid  in  1  writeback slot holds a real instruction
wb_exception  in  1  instruction in writeback raised a synchronous exception
wb_ecause  in  4  exception cause code
wb_mret  in  1  instruction in writeback is mret
wb_wfi  in  1  instruction in writeback is wfi
wb_pc  in  32  PC of writeback instruction
wb_next_pc  in  32  PC+4 of writeback instruction
irq_raw  in  3  {meip, mtip, msip} raw pending lines
irq_en  in  3  {meie, mtie, msie} from mie CSR
mstatus_mie  in  1  global interrupt enable
mtvec  in  32  trap vector CSR
mepc  in  32  current mepc CSR (mret target)
eip, tip, sip  out  1 each  registered, gated interrupt requests to writeback
trap_take  out  1  one-cycle pulse: CSR must latch trap_cause/trap_interrupt/trap_epc
trap_cause  out  4  cause code; valid with trap_take
trap_interrupt  out  1  1 = interrupt, 0 = exception; valid with trap_take
trap_epc  out  32  PC to store in mepc; valid with trap_take
redirect_valid  out  1  one-cycle pulse: fetch loads redirect_pc
redirect_pc  out  32  new fetch PC
flush  out  1  kill all younger instructions
stall  out  1  hold pipeline (WFI sleep)

Behaviour:
- Reset (reset_n=0, async): state=RUN; eip/tip/sip, trap_take, redirect_valid, flush, stall = 0; trap_cause, trap_interrupt, trap_epc, redirect_pc = 0; flush counter = 0. Deasserting reset mid-flush or mid-sleep restarts cleanly in RUN.
- All outputs are registered. A decision made from cycle N inputs is visible in cycle N+1.
- pend = irq_raw & irq_en & {3{mstatus_mie}}. In RUN, eip/tip/sip <= pend; in FLUSH they are forced 0.
- Priority, highest first: eip (cause 11) > tip (7) > sip (3) > wb_valid&&wb_exception (wb_ecause) > wb_valid&&wb_mret > wb_valid&&wb_wfi.
- RUN, trap event (pend != 0, or wb_valid&&wb_exception):
  - trap_take=1 and redirect_valid=1 for one cycle.
  - trap_epc = wb_wfi ? wb_next_pc : wb_pc.
  - redirect_pc = {mtvec[31:2],2'b00}. If VECTORED_EN && mtvec[1:0]==1 && interrupt, add 4*cause (32-bit wrap).
  - Go to FLUSH; counter = FLUSH_CYCLES.
- RUN, mret (no trap): redirect_valid=1, redirect_pc=mepc, trap_take=0. Go to FLUSH.
- RUN, wfi (no trap): stall=1 from next cycle; save wb_next_pc; go to SLEEP.
- FLUSH: flush=1 while counter != 0; counter decrements every cycle. At 0, flush=0 and go to RUN. New wb events are ignored in FLUSH; their instructions are already killed.
- SLEEP: stall=1. Wake condition is (irq_raw & irq_en) != 0, independent of mstatus_mie.
  - Wake with pend != 0: take the trap exactly as in RUN, with trap_epc = saved next_pc.
  - Wake with pend == 0: go to RUN; stall drops next cycle; execution resumes at saved next_pc with no redirect.
- Simultaneous interrupt and wfi in RUN: the trap wins; trap_epc = wb_next_pc; no SLEEP entry.
- Simultaneous exception and mret: the exception wins.
- trap_take and redirect_valid never exceed one cycle high. flush and stall are never high together.

Test Plan:
- Reset mid-FLUSH: assert reset_n=0 with counter=2 -> all outputs 0 immediately; after release, state RUN with flush=0.
- Exception: wb_valid=1, wb_exception=1, wb_ecause=2, wb_pc=0x100, mtvec=0x8000_0001 -> next cycle trap_take=1, cause=2, interrupt=0, epc=0x100, redirect_pc=0x8000_0000; flush high exactly 3 cycles.
- Vectored timer interrupt: irq_raw=3'b010, irq_en=3'b010, mstatus_mie=1, mtvec=0x8000_0001 -> tip=1, trap cause=7, interrupt=1, redirect_pc=0x8000_001C.
- mret: wb_valid=1, wb_mret=1, mepc=0x2040 -> redirect_valid pulse with redirect_pc=0x2040, trap_take=0, flush 3 cycles.
- WFI: wfi at pc 0x300 with mstatus_mie=0, then irq_raw=3'b100, irq_en=3'b100 after 10 cycles -> stall high 10+ cycles, drops with no redirect. Repeat with mstatus_mie=1 -> trap cause=11, epc=0x304.
- Priority: eip and sip pending simultaneously with an exception in writeback -> cause=11, interrupt=1, single trap_take pulse.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: decides when control flow leaves the sequential PC path.
// Takes traps (interrupts and synchronous exceptions), performs mret returns
// and parks the pipeline in WFI sleep. Every output is registered, so a
// decision made from cycle N inputs becomes visible in cycle N+1.
module trap_sequencer #(
   parameter int unsigned FLUSH_CYCLES = 3,    // flush length after a redirect, 1..15
   parameter bit          VECTORED_EN  = 1'b1  // honour mtvec.MODE=1 for interrupts
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wb_valid,
   input  logic        wb_exception,
   input  logic [3:0]  wb_ecause,
   input  logic        wb_mret,
   input  logic        wb_wfi,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_next_pc,
   input  logic [2:0]  irq_raw,
   input  logic [2:0]  irq_en,
   input  logic        mstatus_mie,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        eip,
   output logic        tip,
   output logic        sip,
   output logic        trap_take,
   output logic [3:0]  trap_cause,
   output logic        trap_interrupt,
   output logic [31:0] trap_epc,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        stall
);

   typedef enum logic [1:0] {RUN, FLUSH, SLEEP} state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [31:0] saved_pc, saved_pc_nx;

   logic [2:0]  irq_nx;
   logic        take_nx, intr_nx, redirect_nx, flush_nx, stall_nx;
   logic [3:0]  cause_nx;
   logic [31:0] epc_nx, rpc_nx;

   // Interrupt qualification, fixed priority and trap vector targets.
   logic [2:0]  pend;
   logic        wake;
   logic [3:0]  int_cause;
   logic [31:0] vec_base, vec_int;
   logic        do_trap;
   logic [31:0] epc_src;

   assign pend      = irq_raw & irq_en & {3{mstatus_mie}};
   // Waking from WFI ignores the global enable; only the per-source enables matter.
   assign wake      = |(irq_raw & irq_en);
   assign int_cause = pend[2] ? 4'd11 : (pend[1] ? 4'd7 : 4'd3);
   assign vec_base  = {mtvec[31:2], 2'b00};
   assign vec_int   = (VECTORED_EN && (mtvec[1:0] == 2'b01))
                      ? vec_base + {26'd0, int_cause, 2'b00} : vec_base;

   // Next-state and next-output decision for the trap/mret/wfi FSM.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path leaves
      // one unassigned; a missed default would infer a latch.
      state_nx    = state;
      cnt_nx      = cnt;
      saved_pc_nx = saved_pc;
      irq_nx      = 3'b000;
      take_nx     = 1'b0;
      redirect_nx = 1'b0;
      flush_nx    = 1'b0;
      stall_nx    = 1'b0;
      cause_nx    = trap_cause;
      intr_nx     = trap_interrupt;
      epc_nx      = trap_epc;
      rpc_nx      = redirect_pc;
      do_trap     = 1'b0;
      epc_src     = wb_pc;

      case (state)
         RUN: begin
            irq_nx  = pend;
            do_trap = (pend != 3'b000) || (wb_valid && wb_exception);
            epc_src = wb_wfi ? wb_next_pc : wb_pc;
            if (!do_trap) begin
               if (wb_valid && wb_mret) begin
                  redirect_nx = 1'b1;
                  rpc_nx      = mepc;
                  flush_nx    = 1'b1;
                  cnt_nx      = FLUSH_LOAD;
                  state_nx    = FLUSH;
               end else if (wb_valid && wb_wfi) begin
                  saved_pc_nx = wb_next_pc;
                  stall_nx    = 1'b1;
                  state_nx    = SLEEP;
               end
            end
         end
         FLUSH: begin
            // Younger instructions are already dead; writeback events are ignored.
            if (cnt > 4'd1) begin
               cnt_nx   = cnt - 4'd1;
               flush_nx = 1'b1;
            end else begin
               cnt_nx   = 4'd0;
               state_nx = RUN;
            end
         end
         SLEEP: begin
            irq_nx  = pend;
            do_trap = (pend != 3'b000);
            epc_src = saved_pc;
            if (!do_trap) begin
               if (wake) state_nx = RUN;
               else      stall_nx = 1'b1;
            end
         end
         default: state_nx = RUN;
      endcase

      // Trap entry is identical from RUN and from SLEEP apart from the epc source.
      if (do_trap) begin
         take_nx     = 1'b1;
         redirect_nx = 1'b1;
         intr_nx     = (pend != 3'b000);
         cause_nx    = (pend != 3'b000) ? int_cause : wb_ecause;
         rpc_nx      = (pend != 3'b000) ? vec_int : vec_base;
         epc_nx      = epc_src;
         flush_nx    = 1'b1;
         stall_nx    = 1'b0;
         cnt_nx      = FLUSH_LOAD;
         state_nx    = FLUSH;
      end
   end

   // State and registered outputs; reset returns cleanly to RUN with all outputs low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RUN;
         cnt            <= 4'd0;
         saved_pc       <= 32'd0;
         {eip, tip, sip} <= 3'b000;
         trap_take      <= 1'b0;
         trap_cause     <= 4'd0;
         trap_interrupt <= 1'b0;
         trap_epc       <= 32'd0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
         flush          <= 1'b0;
         stall          <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // computed from this cycle's state, independent of statement order.
         state          <= state_nx;
         cnt            <= cnt_nx;
         saved_pc       <= saved_pc_nx;
         {eip, tip, sip} <= irq_nx;
         trap_take      <= take_nx;
         trap_cause     <= cause_nx;
         trap_interrupt <= intr_nx;
         trap_epc       <= epc_nx;
         redirect_valid <= redirect_nx;
         redirect_pc    <= rpc_nx;
         flush          <= flush_nx;
         stall          <= stall_nx;
      end
   end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios followed by random
// traffic, checked through a scoreboard fed by a behavioural reference model.
module tb_trap_sequencer;

   localparam int unsigned FLUSH_CYCLES = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wb_valid = 1'b0, wb_exception = 1'b0, wb_mret = 1'b0, wb_wfi = 1'b0;
   logic [3:0]  wb_ecause = '0;
   logic [31:0] wb_pc = '0, wb_next_pc = '0;
   logic [2:0]  irq_raw = '0, irq_en = '0;
   logic        mstatus_mie = 1'b0;
   logic [31:0] mtvec = '0, mepc = '0;
   logic        eip, tip, sip, trap_take, trap_interrupt, redirect_valid, flush, stall;
   logic [3:0]  trap_cause;
   logic [31:0] trap_epc, redirect_pc;

   trap_sequencer #(.FLUSH_CYCLES(FLUSH_CYCLES), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .wb_valid(wb_valid), .wb_exception(wb_exception), .wb_ecause(wb_ecause),
      .wb_mret(wb_mret), .wb_wfi(wb_wfi), .wb_pc(wb_pc), .wb_next_pc(wb_next_pc),
      .irq_raw(irq_raw), .irq_en(irq_en), .mstatus_mie(mstatus_mie),
      .mtvec(mtvec), .mepc(mepc),
      .eip(eip), .tip(tip), .sip(sip),
      .trap_take(trap_take), .trap_cause(trap_cause), .trap_interrupt(trap_interrupt),
      .trap_epc(trap_epc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .stall(stall)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected per-cycle control outputs and expected redirect events.
   typedef struct {
      int unsigned cyc;
      logic [2:0]  irq;
      logic        e_flush;
      logic        e_stall;
      logic        e_take;
      logic        e_redir;
   } cyc_exp_t;

   typedef struct {
      int unsigned cyc;
      logic        take;
      logic [3:0]  cause;
      logic        intr;
      logic [31:0] epc;
      logic [31:0] pc;
   } evt_exp_t;

   cyc_exp_t cq[$];
   evt_exp_t eq[$];
   bit       mon_on = 1'b0;

   // Reference model: busy = flush cycles still owed, sleeping/saved = WFI state.
   int          m_busy = 0;
   bit          m_sleep = 1'b0;
   logic [31:0] m_saved = '0;

   function automatic logic [31:0] trap_target(input logic [3:0] cause, input logic intr);
      logic [31:0] base;
      base = mtvec & 32'hFFFF_FFFC;
      if (intr && (mtvec[1:0] == 2'b01)) return base + 32'(cause) * 32'd4;
      return base;
   endfunction

   task automatic model_step();
      logic [2:0]  pend;
      logic [2:0]  irq_o;
      logic        fl, st, tk, rv, intr;
      logic [3:0]  cause;
      logic [31:0] epc, tgt;
      pend  = irq_raw & irq_en & {3{mstatus_mie}};
      irq_o = 3'b000;
      {fl, st, tk, rv, intr} = '0;
      cause = '0; epc = '0; tgt = '0;
      if (m_busy > 0) begin
         m_busy--;
         fl = (m_busy > 0);
      end else begin
         irq_o = pend;
         if (pend != 0) begin
            tk = 1'b1; intr = 1'b1;
            cause = pend[2] ? 4'd11 : (pend[1] ? 4'd7 : 4'd3);
            epc = m_sleep ? m_saved : (wb_wfi ? wb_next_pc : wb_pc);
         end else if (!m_sleep && wb_valid && wb_exception) begin
            tk = 1'b1; cause = wb_ecause;
            epc = wb_wfi ? wb_next_pc : wb_pc;
         end
         if (tk) begin
            rv = 1'b1; tgt = trap_target(cause, intr);
            m_sleep = 1'b0;
         end else if (m_sleep) begin
            if ((irq_raw & irq_en) != 0) m_sleep = 1'b0;
            else st = 1'b1;
         end else if (wb_valid && wb_mret) begin
            rv = 1'b1; tgt = mepc;
         end else if (wb_valid && wb_wfi) begin
            m_sleep = 1'b1; m_saved = wb_next_pc; st = 1'b1;
         end
         if (rv) begin
            m_busy = FLUSH_CYCLES;
            fl = 1'b1;
         end
      end
      cq.push_back('{cyc: cyc + 1, irq: irq_o, e_flush: fl, e_stall: st, e_take: tk, e_redir: rv});
      if (rv) eq.push_back('{cyc: cyc + 1, take: tk, cause: cause, intr: intr, epc: epc, pc: tgt});
   endtask

   // Monitor: compares control outputs every cycle and each presented redirect.
   initial begin
      cyc_exp_t c;
      evt_exp_t e;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
               e = eq.pop_front();
               checks++; failures++;
               $display("FAIL missed_event: expected redirect to %0h at cycle %0d never seen", e.pc, e.cyc);
            end
            if (cq.size() > 0 && cq[0].cyc == cyc) begin
               c = cq.pop_front();
               check("ctrl{eip,tip,sip,flush,stall,take,redir}",
                     96'({eip, tip, sip, flush, stall, trap_take, redirect_valid}),
                     96'({c.irq, c.e_flush, c.e_stall, c.e_take, c.e_redir}));
            end
            if (trap_take || redirect_valid) begin
               if (eq.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_event: redirect to %0h with nothing expected", redirect_pc);
               end else begin
                  e = eq.pop_front();
                  check("event_cycle", 96'(cyc), 96'(e.cyc));
                  check("redirect_pc", 96'(redirect_pc), 96'(e.pc));
                  if (e.take)
                     check("trap{cause,intr,epc}", 96'({trap_cause, trap_interrupt, trap_epc}),
                           96'({e.cause, e.intr, e.epc}));
               end
            end
         end
      end
   end

   task automatic step();
      model_step();
      @(negedge clk);
   endtask

   task automatic set_idle();
      wb_valid = 1'b0; wb_exception = 1'b0; wb_mret = 1'b0; wb_wfi = 1'b0;
      irq_raw = 3'b000;
   endtask

   task automatic all_zero_check(input string name);
      check(name, 96'({eip, tip, sip, trap_take, trap_cause, trap_interrupt, trap_epc,
                       redirect_valid, redirect_pc, flush, stall}), 96'd0);
   endtask

   task automatic model_reset();
      m_busy = 0; m_sleep = 1'b0; m_saved = '0;
   endtask

   task automatic exception_at(input logic [3:0] cause, input logic [31:0] pc);
      wb_valid = 1'b1; wb_exception = 1'b1; wb_ecause = cause;
      wb_pc = pc; wb_next_pc = pc + 32'd4;
      step();
      set_idle();
   endtask

   task automatic wfi_scenario(input logic mie);
      mstatus_mie = mie; irq_en = 3'b100; mtvec = 32'h8000_0001;
      wb_valid = 1'b1; wb_wfi = 1'b1; wb_pc = 32'h300; wb_next_pc = 32'h304;
      step();
      set_idle();
      repeat (10) step();
      irq_raw = 3'b100;
      step();
      irq_raw = 3'b000;
      repeat (FLUSH_CYCLES + 2) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      #12;
      all_zero_check("reset_outputs");
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      mon_on = 1'b1;
      step();

      // Exception with vectored mtvec (exceptions use the base address)
      mtvec = 32'h8000_0001;
      exception_at(4'd2, 32'h100);
      repeat (FLUSH_CYCLES + 2) step();

      // Vectored timer interrupt
      irq_raw = 3'b010; irq_en = 3'b010; mstatus_mie = 1'b1;
      step();
      set_idle();
      repeat (FLUSH_CYCLES + 2) step();

      // mret
      wb_valid = 1'b1; wb_mret = 1'b1; mepc = 32'h2040;
      step();
      set_idle();
      repeat (FLUSH_CYCLES + 2) step();

      // WFI woken without global enable, then with it
      wfi_scenario(1'b0);
      wfi_scenario(1'b1);

      // Priority: eip and sip pending together with an exception
      irq_en = 3'b111; mstatus_mie = 1'b1; irq_raw = 3'b101;
      wb_valid = 1'b1; wb_exception = 1'b1; wb_ecause = 4'd5; wb_pc = 32'h440; wb_next_pc = 32'h444;
      step();
      set_idle();
      repeat (FLUSH_CYCLES + 2) step();

      // Simultaneous interrupt and wfi: trap wins with epc = next pc
      irq_raw = 3'b001; wb_valid = 1'b1; wb_wfi = 1'b1; wb_pc = 32'h500; wb_next_pc = 32'h504;
      step();
      set_idle();
      repeat (FLUSH_CYCLES + 2) step();

      // Reset while flushing with two flush cycles still to go
      exception_at(4'd1, 32'h600);
      step();
      #2;
      mon_on = 1'b0;
      reset_n = 1'b0;
      #1;
      all_zero_check("reset_mid_flush");
      cq.delete();
      eq.delete();
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      model_reset();
      @(negedge clk);
      mon_on = 1'b1;
      repeat (3) step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         int op;
         op = int'($urandom_range(0, 19));
         wb_valid     = ($urandom_range(0, 9) < 7);
         wb_exception = (op < 2) || (op == 6);
         wb_mret      = (op == 2) || (op == 3) || (op == 6);
         wb_wfi       = (op == 4) || (op == 5);
         wb_ecause    = 4'($urandom);
         wb_pc        = $urandom & 32'hFFFF_FFFC;
         wb_next_pc   = wb_pc + 32'd4;
         irq_raw      = {($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
                         ($urandom_range(0, 39) == 0)};
         irq_en       = 3'($urandom);
         mstatus_mie  = ($urandom_range(0, 3) != 0);
         mtvec        = $urandom;
         mepc         = $urandom & 32'hFFFF_FFFC;
         step();
      end

      // Drain and confirm nothing expected was left unseen
      set_idle();
      irq_en = 3'b111;
      irq_raw = 3'b000;
      repeat (FLUSH_CYCLES + 3) step();
      check("pending_events", 96'(eq.size()), 96'd0);
      check("pending_cycles", 96'(cq.size()), 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
